// File: rtl/sram_port_arbiter.sv
// Shares one 32-bit synchronous SRAM between a 64-bit two-beat fetch port
// and a 32-bit load/store port, with round-robin or data-first arbitration.
module sram_port_arbiter #(
  parameter bit FAIR = 1'b1
) (
  input  logic        clk,
  input  logic        resetn,
  input  logic        inst_req,
  input  logic [31:0] inst_addr,
  output logic        inst_addr_ok,
  output logic        inst_data_ok,
  output logic [63:0] inst_rdata,
  input  logic        data_req,
  input  logic        data_wr,
  input  logic [3:0]  data_wstrb,
  input  logic [31:0] data_addr,
  input  logic [31:0] data_wdata,
  output logic        data_addr_ok,
  output logic        data_data_ok,
  output logic [31:0] data_rdata,
  output logic        mem_en,
  output logic [3:0]  mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    I_HI,
    I_DONE,
    D_DONE
  } state_t;

  state_t      state_q, state_d;
  logic [28:0] base_q, base_d;
  logic [31:0] lo_q, lo_d;
  logic        last_inst_q, last_inst_d;
  logic        grant_inst, grant_data;
  logic        unused_bits;

  assign unused_bits = ^inst_addr[2:0];

  // Conflict: alternate when fair, otherwise the data port always wins
  always_comb begin
    grant_inst = 1'b0;
    grant_data = 1'b0;
    if (state_q == IDLE) begin
      if (inst_req && data_req) begin
        grant_inst = FAIR && !last_inst_q;
        grant_data = !grant_inst;
      end else begin
        grant_inst = inst_req;
        grant_data = data_req;
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    base_d       = base_q;
    lo_d         = lo_q;
    last_inst_d  = last_inst_q;
    inst_addr_ok = 1'b0;
    inst_data_ok = 1'b0;
    data_addr_ok = 1'b0;
    data_data_ok = 1'b0;
    mem_en       = 1'b0;
    mem_wen      = 4'b0;
    mem_addr     = 32'b0;
    mem_wdata    = 32'b0;
    unique case (state_q)
      IDLE: begin
        if (grant_inst) begin
          inst_addr_ok = 1'b1;
          mem_en       = 1'b1;
          mem_addr     = {inst_addr[31:3], 3'b000};
          base_d       = inst_addr[31:3];
          last_inst_d  = 1'b1;
          state_d      = I_HI;
        end else if (grant_data) begin
          data_addr_ok = 1'b1;
          mem_en       = 1'b1;
          mem_addr     = data_addr;
          mem_wdata    = data_wdata;
          mem_wen      = data_wr ? data_wstrb : 4'b0;
          last_inst_d  = 1'b0;
          state_d      = D_DONE;
        end
      end
      I_HI: begin
        mem_en   = 1'b1;
        mem_addr = {base_q, 3'b100};
        lo_d     = mem_rdata;
        state_d  = I_DONE;
      end
      I_DONE: begin
        inst_data_ok = 1'b1;
        state_d      = IDLE;
      end
      D_DONE: begin
        data_data_ok = 1'b1;
        state_d      = IDLE;
      end
    endcase
    if (!resetn) begin
      inst_addr_ok = 1'b0;
      inst_data_ok = 1'b0;
      data_addr_ok = 1'b0;
      data_data_ok = 1'b0;
      mem_en       = 1'b0;
      mem_wen      = 4'b0;
      mem_addr     = 32'b0;
      mem_wdata    = 32'b0;
    end
  end

  assign inst_rdata = resetn ? {mem_rdata, lo_q} : 64'b0;
  assign data_rdata = resetn ? mem_rdata : 32'b0;

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q     <= IDLE;
      base_q      <= '0;
      lo_q        <= '0;
      last_inst_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      base_q      <= base_d;
      lo_q        <= lo_d;
      last_inst_q <= last_inst_d;
    end
  end

endmodule
